sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single SRAM port between two requesters: CPU memory path (port 0, Mem2IO side) and the program loader/debug path (port 1).
- Sequences each access as setup → strobe (WAIT_CYCLES) → ack, generating active-low OE/WE, the SRAM address and the write data.
- Sits between the requesters and the SRAM pins in the SLC-3 top level and replaces direct MAR→ADDR / ISDU→OE/WE wiring.

Parameters:
- WAIT_CYCLES, 2, number of cycles OE or WE is held asserted per access; legal range 1..15.

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Req0, Req1  input  1 each  access request, port 0 (CPU) / port 1 (loader)
- WE_req0, WE_req1  input  1 each  1 = write, 0 = read
- Addr0, Addr1  input  16 each  word address
- WData0, WData1  input  16 each  write data
- Ack0, Ack1  output  1 each  one-cycle completion pulse
- RData  output  16  read data, valid when Ack0/Ack1 is high after a read
- Busy  output  1  high in any state other than IDLE
- Gnt_id  output  1  port owning the current/last transaction
- ADDR  output  16  SRAM address
- Data_to_SRAM  output  16  SRAM write data
- Data_from_SRAM  input  16  SRAM read data
- OE, WE  output  1 each  SRAM strobes, active-low

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE.
  - OE=1, WE=1.
  - Ack0=Ack1=0, Busy=0, Gnt_id=0.
  - ADDR=0, Data_to_SRAM=0, RData=0.
  - Last-grant pointer = 1, so port 0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any Req is high: choose a winner, latch its Addr, WData and WE_req into internal registers, set Gnt_id, then go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration (round-robin):
  - Only one requester → grant it.
  - Both requesting → grant the port that is not the last-grant pointer.
  - The pointer updates to the winner on every grant.
- SETUP (1 cycle):
  - ADDR = latched address; Data_to_SRAM = latched data for a write, else holds its previous value.
  - OE=WE=1.
  - Load the wait counter with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - Read: OE=0. Write: WE=0. Never both low.
  - Counter decrements each cycle; at count 0 go to DONE.
  - On a read, RData captures Data_from_SRAM on that final ACCESS edge.
- DONE (1 cycle):
  - OE=WE=1.
  - Ack of Gnt_id = 1, the other Ack = 0.
  - Then return to IDLE.
- Latency: the request is sampled at edge E; the Ack pulse is high in the cycle starting at edge E+WAIT_CYCLES+2. Back-to-back accesses to the same port are therefore spaced WAIT_CYCLES+3 cycles apart.
- Requester rules:
  - Hold Req, WE_req, Addr and WData stable from assertion until Ack is sampled high.
  - On the edge where Ack is sampled, either drop Req or present the next request.
  - A Req still high in the IDLE after DONE is treated as a new transaction.
- Address/data stability:
  - ADDR and Data_to_SRAM stay constant from SETUP through DONE.
  - Both hold their last values in IDLE; there are no glitches between accesses.
- RData holds its value until the next read completes; writes leave it unchanged.
- Requests dropped mid-transaction are ignored; the transaction always completes.
- Reset asserted mid-operation: strobes go high immediately (async), state goes to IDLE, no Ack is issued, and the pointer is reset.
- WAIT_CYCLES=1: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro SRAM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority, port 0 always wins when both request; the last-grant pointer is unused. Port 1 can starve.
- Undefined: round-robin as above.

Test Plan:
- Port 0 read, Addr0=16'h0042, WAIT_CYCLES=2, SRAM returns 16'hBEEF → OE low for exactly 2 cycles, WE stays high, Ack0 one cycle 4 cycles after the sampling edge, RData=16'hBEEF, Ack1 never asserted.
- Port 1 write, Addr1=16'h0100, WData1=16'h1234 → ADDR=16'h0100 and Data_to_SRAM=16'h1234 stable SETUP..DONE, WE low 2 cycles, OE stays high, Ack1 pulse, RData unchanged.
- Req0 and Req1 held high for 4 transactions → grant order 0,1,0,1, each Ack a single cycle, accesses 5 cycles apart.
- Reset_n pulled low during ACCESS of a write → WE=1 in the same cycle without waiting for a clock, no Ack; after release, Req1 alone gets an immediate grant.
- Port 0 back-to-back reads to 16'h0000 and then 16'h0001 → two Ack0 pulses 5 cycles apart, ADDR transitions only in SETUP.
- With SRAM_ARB_CPU_PRIORITY_EN defined, both requests held → port 0 granted every transaction, Ack1 never asserted until Req0 drops.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter sequencing SETUP -> ACCESS -> DONE on a single async SRAM port.
// Define SRAM_ARB_CPU_PRIORITY_EN for fixed priority to port 0 (CPU) instead of round-robin.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        WE_req0,
    input  logic        WE_req1,
    input  logic [15:0] Addr0,
    input  logic [15:0] Addr1,
    input  logic [15:0] WData0,
    input  logic [15:0] WData1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [15:0] RData,
    output logic        Busy,
    output logic        Gnt_id,
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        OE,
    output logic        WE
);

    // state  | meaning
    // IDLE   | sample requests, pick winner, latch address/data
    // SETUP  | address/data driven, strobes high, load wait counter
    // ACCESS | OE or WE low for WAIT_CYCLES cycles
    // DONE   | strobes high; Ack pulse is registered on exit
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       we_lat;
    logic       winner;

`ifdef SRAM_ARB_CPU_PRIORITY_EN
    always_comb begin
        winner = ~Req0;
    end
`else
    logic last_gnt;

    always_comb begin
        winner = ~Req0;
        if (Req0 && Req1)
            winner = ~last_gnt;
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            we_lat       <= 1'b0;
            OE           <= 1'b1;
            WE           <= 1'b1;
            Ack0         <= 1'b0;
            Ack1         <= 1'b0;
            Busy         <= 1'b0;
            Gnt_id       <= 1'b0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            RData        <= '0;
`ifndef SRAM_ARB_CPU_PRIORITY_EN
            last_gnt     <= 1'b1;
`endif
        end else begin
            Ack0 <= 1'b0;
            Ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req0 || Req1) begin
                        state  <= SETUP;
                        Busy   <= 1'b1;
                        Gnt_id <= winner;
`ifndef SRAM_ARB_CPU_PRIORITY_EN
                        last_gnt <= winner;
`endif
                        ADDR   <= winner ? Addr1 : Addr0;
                        we_lat <= winner ? WE_req1 : WE_req0;
                        // Reads leave the write-data bus untouched to avoid needless pin toggling
                        if (winner ? WE_req1 : WE_req0)
                            Data_to_SRAM <= winner ? WData1 : WData0;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= CNT_LOAD;
                    if (we_lat)
                        WE <= 1'b0;
                    else
                        OE <= 1'b0;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        OE    <= 1'b1;
                        WE    <= 1'b1;
                        if (!we_lat)
                            RData <= Data_from_SRAM;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Ack0  <= ~Gnt_id;
                    Ack1  <= Gnt_id;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (WAIT_CYCLES=2 main instance, WAIT_CYCLES=1 side instance).
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req0, Req1, WE_req0, WE_req1;
    logic [15:0] Addr0, Addr1, WData0, WData1;
    logic        Ack0, Ack1, Busy, Gnt_id, OE, WE;
    logic [15:0] RData, ADDR, Data_to_SRAM, Data_from_SRAM;

    logic        q_req0, q_req1, q_we0, q_we1;
    logic [15:0] q_addr0, q_addr1, q_wdata0, q_wdata1;
    logic        q_ack0, q_ack1, q_busy, q_gnt, q_oe, q_we;
    logic [15:0] q_rdata, q_addr, q_dts;

    int errors = 0;
    int checks = 0;
    logic expg;

    always #5 Clk = ~Clk;

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .WE_req0(WE_req0), .WE_req1(WE_req1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(Ack0), .Ack1(Ack1), .RData(RData), .Busy(Busy), .Gnt_id(Gnt_id),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .OE(OE), .WE(WE)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0(q_req0), .Req1(q_req1), .WE_req0(q_we0), .WE_req1(q_we1),
        .Addr0(q_addr0), .Addr1(q_addr1), .WData0(q_wdata0), .WData1(q_wdata1),
        .Ack0(q_ack0), .Ack1(q_ack1), .RData(q_rdata), .Busy(q_busy), .Gnt_id(q_gnt),
        .ADDR(q_addr), .Data_to_SRAM(q_dts), .Data_from_SRAM(Data_from_SRAM),
        .OE(q_oe), .WE(q_we)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        Req0 = 0; Req1 = 0; WE_req0 = 0; WE_req1 = 0;
        Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0; Data_from_SRAM = '0;
        q_req0 = 0; q_req1 = 0; q_we0 = 0; q_we1 = 0;
        q_addr0 = '0; q_addr1 = '0; q_wdata0 = '0; q_wdata1 = '0;

        // reset state
        cyc(); cyc();
        chk1("rst_oe", OE, 1'b1);
        chk1("rst_we", WE, 1'b1);
        chk1("rst_ack0", Ack0, 1'b0);
        chk1("rst_ack1", Ack1, 1'b0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_gnt", Gnt_id, 1'b0);
        chk16("rst_addr", ADDR, 16'h0000);
        chk16("rst_dts", Data_to_SRAM, 16'h0000);
        chk16("rst_rdata", RData, 16'h0000);
        Reset_n = 1'b1;
        cyc();

        // port 0 read of 0x0042
        Data_from_SRAM = 16'hBEEF; Req0 = 1; WE_req0 = 0; Addr0 = 16'h0042;
        cyc();
        chk1("t1_busy", Busy, 1'b1);
        chk1("t1_gnt", Gnt_id, 1'b0);
        chk16("t1_addr", ADDR, 16'h0042);
        chk1("t1_setup_oe", OE, 1'b1);
        cyc();
        chk1("t1_acc1_oe", OE, 1'b0);
        chk1("t1_acc1_we", WE, 1'b1);
        cyc();
        chk1("t1_acc2_oe", OE, 1'b0);
        chk1("t1_acc2_ack0", Ack0, 1'b0);
        cyc();
        chk1("t1_done_oe", OE, 1'b1);
        chk1("t1_done_ack0", Ack0, 1'b0);
        cyc();
        chk1("t1_ack0", Ack0, 1'b1);
        chk1("t1_ack1", Ack1, 1'b0);
        chk16("t1_rdata", RData, 16'hBEEF);
        chk1("t1_busy_end", Busy, 1'b0);
        Req0 = 0;
        cyc();
        chk1("t1_ack0_pulse", Ack0, 1'b0);

        // port 1 write 0x1234 to 0x0100
        Req1 = 1; WE_req1 = 1; Addr1 = 16'h0100; WData1 = 16'h1234;
        cyc();
        chk1("t2_gnt", Gnt_id, 1'b1);
        chk16("t2_addr_s", ADDR, 16'h0100);
        chk16("t2_dts_s", Data_to_SRAM, 16'h1234);
        chk1("t2_setup_we", WE, 1'b1);
        cyc();
        chk1("t2_acc1_we", WE, 1'b0);
        chk1("t2_acc1_oe", OE, 1'b1);
        cyc();
        chk1("t2_acc2_we", WE, 1'b0);
        chk16("t2_dts_a", Data_to_SRAM, 16'h1234);
        cyc();
        chk1("t2_done_we", WE, 1'b1);
        chk16("t2_addr_d", ADDR, 16'h0100);
        chk1("t2_done_ack1", Ack1, 1'b0);
        cyc();
        chk1("t2_ack1", Ack1, 1'b1);
        chk1("t2_ack0", Ack0, 1'b0);
        chk16("t2_rdata_kept", RData, 16'hBEEF);
        Req1 = 0; WE_req1 = 0;
        cyc();

        // both ports held for four transactions
        Data_from_SRAM = 16'h5555;
        Req0 = 1; WE_req0 = 0; Addr0 = 16'h0010;
        Req1 = 1; WE_req1 = 0; Addr1 = 16'h0020;
        cyc();
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_CPU_PRIORITY_EN
            expg = 1'b0;
`else
            expg = (k % 2) == 1;
`endif
            chk1("t3_gnt", Gnt_id, expg);
            chk16("t3_addr", ADDR, expg ? 16'h0020 : 16'h0010);
            chk1("t3_ack0_low", Ack0, 1'b0);
            chk1("t3_ack1_low", Ack1, 1'b0);
            cyc(); cyc(); cyc();
            chk1("t3_done_ack0", Ack0, 1'b0);
            chk1("t3_done_ack1", Ack1, 1'b0);
            cyc();
            chk1("t3_ack0", Ack0, ~expg);
            chk1("t3_ack1", Ack1, expg);
            chk16("t3_rdata", RData, 16'h5555);
            if (k == 3) begin
                Req0 = 0; Req1 = 0;
            end
            cyc();
        end
        chk16("t3_dts_kept", Data_to_SRAM, 16'h1234);
        chk1("t3_idle", Busy, 1'b0);

        // reset during ACCESS of a write
        Req0 = 1; WE_req0 = 1; Addr0 = 16'h0300; WData0 = 16'hAAAA;
        cyc();
        chk1("t4_gnt", Gnt_id, 1'b0);
        cyc();
        chk1("t4_acc_we", WE, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        chk1("t4_async_we", WE, 1'b1);
        chk1("t4_async_oe", OE, 1'b1);
        chk1("t4_async_busy", Busy, 1'b0);
        chk16("t4_async_addr", ADDR, 16'h0000);
        chk16("t4_async_rdata", RData, 16'h0000);
        Req0 = 0; WE_req0 = 0;
        cyc();
        chk1("t4_noack0_a", Ack0, 1'b0);
        cyc();
        chk1("t4_noack0_b", Ack0, 1'b0);
        Reset_n = 1'b1;
        Data_from_SRAM = 16'h7777;
        Req1 = 1; WE_req1 = 0; Addr1 = 16'h0400;
        cyc();
        chk1("t4_gnt1", Gnt_id, 1'b1);
        chk1("t4_busy", Busy, 1'b1);
        chk16("t4_addr", ADDR, 16'h0400);
        cyc(); cyc(); cyc();
        cyc();
        chk1("t4_ack1", Ack1, 1'b1);
        chk16("t4_rdata", RData, 16'h7777);
        Req1 = 0;
        cyc();

        // port 0 back-to-back reads 0x0000 then 0x0001
        Data_from_SRAM = 16'h1111; Req0 = 1; WE_req0 = 0; Addr0 = 16'h0000;
        cyc();
        chk16("t5_addr_a0", ADDR, 16'h0000);
        cyc();
        chk16("t5_addr_a1", ADDR, 16'h0000);
        cyc();
        chk16("t5_addr_a2", ADDR, 16'h0000);
        cyc();
        chk1("t5_done_a", Ack0, 1'b0);
        cyc();
        chk1("t5_ack_a", Ack0, 1'b1);
        chk16("t5_rdata_a", RData, 16'h1111);
        chk16("t5_addr_hold", ADDR, 16'h0000);
        Addr0 = 16'h0001; Data_from_SRAM = 16'h2222;
        cyc();
        chk1("t5_ack_a_pulse", Ack0, 1'b0);
        chk16("t5_addr_b0", ADDR, 16'h0001);
        cyc(); cyc();
        chk16("t5_rdata_hold", RData, 16'h1111);
        cyc();
        chk1("t5_done_b", Ack0, 1'b0);
        cyc();
        chk1("t5_ack_b", Ack0, 1'b1);
        chk16("t5_rdata_b", RData, 16'h2222);
        Req0 = 0;
        cyc();

        // WAIT_CYCLES=1 instance: single-cycle ACCESS
        Data_from_SRAM = 16'h9999; q_req0 = 1; q_addr0 = 16'h0055;
        cyc();
        chk1("w1_setup_oe", q_oe, 1'b1);
        chk16("w1_addr", q_addr, 16'h0055);
        cyc();
        chk1("w1_acc_oe", q_oe, 1'b0);
        chk1("w1_acc_we", q_we, 1'b1);
        cyc();
        chk1("w1_done_oe", q_oe, 1'b1);
        chk1("w1_done_ack", q_ack0, 1'b0);
        cyc();
        chk1("w1_ack0", q_ack0, 1'b1);
        chk1("w1_ack1", q_ack1, 1'b0);
        chk16("w1_rdata", q_rdata, 16'h9999);
        q_req0 = 0;
        cyc();
        chk1("w1_ack0_pulse", q_ack0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
